// File: rtl/song_sequencer.sv
// Run-time loadable song RAM plus the playback FSM feeding the note player.
// Steps through {note, duration} entries, timing each note in beat strobes.
module song_sequencer #(
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  parameter int SONG_BITS = 2,
  parameter int IDX_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [SONG_BITS+IDX_W-1:0]    wr_addr,
  input  logic [NOTE_W+DUR_W-1:0]       wr_data,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song_sel,
  input  logic                          loop,
  input  logic                          beat,
  output logic [NOTE_W-1:0]             note,
  output logic                          new_note,
  output logic                          playing,
  output logic                          song_done
);

  localparam int ADDR_W  = SONG_BITS + IDX_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, PLAY, DONE} state_t;

  state_t                 state_reg;
  logic [SONG_BITS-1:0]   cur_song_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [DUR_W-1:0]       cnt_reg;
  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     rd_data_reg;

  logic [NOTE_W-1:0]      entry_note;
  logic [DUR_W-1:0]       entry_dur;
  logic                   last_idx;

  assign entry_note = rd_data_reg[ENTRY_W-1:DUR_W];
  assign entry_dur  = rd_data_reg[DUR_W-1:0];
  assign last_idx   = (idx_reg == '1);

  // Read every cycle; DECODE sees the word captured at the end of FETCH.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    rd_data_reg <= mem[{cur_song_reg, idx_reg}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_song_reg <= '0;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      note         <= '0;
      new_note     <= 1'b0;
      playing      <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (play) begin
            cur_song_reg <= song_sel;
            idx_reg      <= '0;
            playing      <= 1'b1;
            state_reg    <= FETCH;
          end
        end
        FETCH: begin
          if (!play) begin
            note      <= '0;
            playing   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (!play) begin
            note      <= '0;
            playing   <= 1'b0;
            state_reg <= IDLE;
          end else if (entry_dur == '0) begin
            if (loop) begin
              idx_reg   <= '0;
              state_reg <= FETCH;
            end else begin
              song_done <= 1'b1;
              playing   <= 1'b0;
              state_reg <= DONE;
            end
          end else begin
            note      <= entry_note;
            new_note  <= 1'b1;
            cnt_reg   <= entry_dur;
            state_reg <= PLAY;
          end
        end
        PLAY: begin
          if (!play) begin
            note      <= '0;
            playing   <= 1'b0;
            state_reg <= IDLE;
          end else if (beat) begin
            if (cnt_reg == DUR_W'(1)) begin
              // Running off the last slot behaves exactly like a marker.
              if (last_idx) begin
                if (loop) begin
                  idx_reg   <= '0;
                  state_reg <= FETCH;
                end else begin
                  song_done <= 1'b1;
                  playing   <= 1'b0;
                  state_reg <= DONE;
                end
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                state_reg <= FETCH;
              end
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
        end
        DONE: begin
          if (!play) begin
            note      <= '0;
            state_reg <= IDLE;
          end
        end
        default: begin
          note      <= '0;
          playing   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Randomised-beat bench for song_sequencer: an event-level song model feeds a
// scoreboard queue that a monitor drains on every new_note / song_done pulse.
module tb_song_sequencer;
  localparam int NSONG = 4;
  localparam int NIDX  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [11:0] wr_data;
  logic        play;
  logic [1:0]  song_sel;
  logic        loop;
  logic        gen_beat;
  logic        man_beat;
  logic        beat;
  logic [5:0]  note;
  logic        new_note;
  logic        playing;
  logic        song_done;

  assign beat = gen_beat | man_beat;

  song_sequencer #(.NOTE_W(6), .DUR_W(6), .SONG_BITS(2), .IDX_W(5)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .play(play), .song_sel(song_sel), .loop(loop), .beat(beat),
    .note(note), .new_note(new_note), .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // kind 0 = note event, 1 = song end; gap = cycles from terminating beat (-1 = unchecked)
  typedef struct {int kind; int note; int dur; int gap;} ev_t;
  ev_t exp_q[$];

  int ref_note [NSONG][NIDX];
  int ref_dur  [NSONG][NIDX];
  int checks = 0;
  int failures = 0;
  int notes_seen = 0;
  int dones_seen = 0;
  int base_notes, base_dones;
  bit beat_en = 1'b0;

  task automatic check(string name, int actual, int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Beat strobes at least 5 edges apart so none lands in an inter-note gap.
  initial begin
    gen_beat = 1'b0;
    forever begin
      repeat ($urandom_range(7, 4)) @(negedge clk);
      gen_beat = beat_en;
      @(negedge clk);
      gen_beat = 1'b0;
    end
  end

  // Monitor / scoreboard
  int   cyc = 0;
  int   last_beat_cyc = -100;
  int   beats_since = 0;
  int   prev_dur = -1;
  bit   mon_beat;
  ev_t  ev;
  always @(posedge clk) begin
    mon_beat = beat;
    #1;
    cyc++;
    if (reset) begin
      prev_dur = -1;
    end else begin
      if (mon_beat) begin
        beats_since++;
        last_beat_cyc = cyc;
      end
      if (new_note || song_done) begin
        check("pulse_overlap", int'(new_note && song_done), 0);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event new_note=%0d song_done=%0d note=%0d required=none",
                   new_note, song_done, note);
        end else begin
          ev = exp_q.pop_front();
          check("event_kind", new_note ? 0 : 1, ev.kind);
          if (new_note) check("note_value", int'(note), ev.note);
          if (ev.gap >= 0) check("gap_cycles", cyc - last_beat_cyc, ev.gap);
          if (prev_dur >= 0) check("beats_per_note", beats_since, prev_dur);
          prev_dur = new_note ? ev.dur : -1;
        end
        beats_since = 0;
        if (new_note) notes_seen++;
        else dones_seen++;
        $display("event t=%0t kind=%s note=%0d", $time, new_note ? "note" : "done", note);
      end else if (!playing) begin
        prev_dur = -1;
      end
    end
  end

  task automatic write_entry(int s, int i, int n, int d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 7'(s * NIDX + i);
    wr_data = {6'(n), 6'(d)};
    @(negedge clk);
    wr_en = 1'b0;
    ref_note[s][i] = n;
    ref_dur[s][i]  = d;
  endtask

  // Expected events for a play of song s lasting 'passes' passes (loop held
  // high for all but the last end event).
  task automatic push_song(int s, int passes);
    ev_t e;
    int  first = 1;
    int  ended_marker = 0;
    int  restart_gap = 2;
    for (int p = 0; p < passes; p++) begin
      ended_marker = 0;
      for (int i = 0; i < NIDX; i++) begin
        if (ref_dur[s][i] == 0) begin
          ended_marker = 1;
          break;
        end
        e.kind = 0;
        e.note = ref_note[s][i];
        e.dur  = ref_dur[s][i];
        e.gap  = first ? -1 : ((i == 0) ? restart_gap : 2);
        exp_q.push_back(e);
        first = 0;
      end
      restart_gap = ended_marker ? 4 : 2;
    end
    e.kind = 1;
    e.note = 0;
    e.dur  = 0;
    e.gap  = first ? -1 : (ended_marker ? 2 : 0);
    exp_q.push_back(e);
  endtask

  task automatic start_play(int s, string name);
    int lat = 0;
    @(negedge clk);
    song_sel = 2'(s);
    play     = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (new_note || song_done) begin
        lat = i;
        break;
      end
    end
    check(name, lat, 3);
  endtask

  task automatic wait_done(int target, string name);
    for (int i = 0; i < 4000; i++) begin
      if (dones_seen >= target) break;
      @(negedge clk);
    end
    check(name, int'(dones_seen >= target), 1);
  endtask

  task automatic wait_notes(int target, string name);
    for (int i = 0; i < 4000; i++) begin
      if (notes_seen >= target) break;
      @(negedge clk);
    end
    check(name, int'(notes_seen >= target), 1);
  endtask

  task automatic stop_play();
    @(negedge clk);
    play = 1'b0;
    @(negedge clk);
    check("stopped_note_zero", int'(note), 0);
  endtask

  initial begin
    reset = 1'b1; play = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    song_sel = 2'd1; loop = 1'b0; man_beat = 1'b0;

    // Reset held with play asserted
    repeat (3) begin
      @(negedge clk);
      check("reset_note", int'(note), 0);
      check("reset_new_note", int'(new_note), 0);
      check("reset_playing", int'(playing), 0);
      check("reset_song_done", int'(song_done), 0);
    end
    play = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_playing", int'(playing), 0);
    check("idle_note", int'(note), 0);

    // Song contents
    write_entry(1, 0, 5, 2);
    write_entry(1, 1, 0, 1);
    write_entry(1, 2, 9, 3);
    write_entry(1, 3, 0, 0);
    for (int k = 0; k < NIDX; k++) write_entry(2, k, k + 1, 1);
    write_entry(3, 0, 11, 1);
    write_entry(3, 1, 12, 1);
    write_entry(3, 2, 0, 0);
    write_entry(0, 0, 7, 0);

    // Basic song
    beat_en = 1'b1;
    base_dones = dones_seen;
    push_song(1, 1);
    start_play(1, "basic_start_latency");
    wait_done(base_dones + 1, "basic_done");
    repeat (3) @(negedge clk);
    check("basic_note_held", int'(note), 9);
    check("basic_playing_low", int'(playing), 0);
    check("basic_queue_drained", exp_q.size(), 0);
    stop_play();

    // Loop for two passes, then finish on the third marker
    loop = 1'b1;
    base_dones = dones_seen;
    base_notes = notes_seen;
    push_song(1, 3);
    start_play(1, "loop_start_latency");
    wait_notes(base_notes + 7, "loop_third_pass");
    loop = 1'b0;
    wait_done(base_dones + 1, "loop_done");
    check("loop_queue_drained", exp_q.size(), 0);
    stop_play();

    // Full 32-entry song without a marker
    base_dones = dones_seen;
    push_song(2, 1);
    start_play(2, "wrap_start_latency");
    wait_done(base_dones + 1, "wrap_done");
    check("wrap_queue_drained", exp_q.size(), 0);
    check("wrap_note_held", int'(note), 32);
    stop_play();

    // Marker at entry 0
    base_dones = dones_seen;
    base_notes = notes_seen;
    push_song(0, 1);
    start_play(0, "empty_done_latency");
    wait_done(base_dones + 1, "empty_done");
    check("empty_no_note", notes_seen, base_notes);
    stop_play();

    // Stop during the second beat of note 5, beat on the same edge
    beat_en = 1'b0;
    repeat (3) @(negedge clk);
    begin
      ev_t e;
      e.kind = 0; e.note = 5; e.dur = 2; e.gap = -1;
      exp_q.push_back(e);
    end
    start_play(1, "stop_start_latency");
    @(negedge clk);
    man_beat = 1'b1;
    @(negedge clk);
    man_beat = 1'b0;
    repeat (2) @(negedge clk);
    man_beat = 1'b1;
    play = 1'b0;
    @(negedge clk);
    man_beat = 1'b0;
    check("stop_note", int'(note), 0);
    check("stop_playing", int'(playing), 0);
    check("stop_new_note", int'(new_note), 0);
    repeat (4) @(negedge clk);
    check("stop_queue_drained", exp_q.size(), 0);
    beat_en = 1'b1;
    base_dones = dones_seen;
    push_song(1, 1);
    start_play(1, "restart_latency");
    wait_done(base_dones + 1, "restart_done");
    stop_play();

    // Overwrite the entry being fetched on the FETCH edge: old data plays
    base_dones = dones_seen;
    push_song(3, 1);
    @(negedge clk);
    song_sel = 2'd3;
    play = 1'b1;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 7'(3 * NIDX);
    wr_data = {6'd40, 6'd1};
    @(negedge clk);
    wr_en = 1'b0;
    ref_note[3][0] = 40;
    ref_dur[3][0]  = 1;
    wait_done(base_dones + 1, "fetch_write_done");
    stop_play();
    base_dones = dones_seen;
    push_song(3, 1);
    start_play(3, "rewritten_start_latency");
    wait_done(base_dones + 1, "rewritten_done");
    stop_play();

    // Asynchronous reset in the middle of note 9, then replay
    base_notes = notes_seen;
    push_song(1, 1);
    start_play(1, "prereset_start_latency");
    wait_notes(base_notes + 3, "prereset_third_note");
    @(negedge clk);
    #2;
    reset = 1'b1;
    play  = 1'b0;
    #1;
    check("async_reset_note", int'(note), 0);
    check("async_reset_playing", int'(playing), 0);
    check("async_reset_new_note", int'(new_note), 0);
    check("async_reset_song_done", int'(song_done), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    base_dones = dones_seen;
    push_song(1, 1);
    start_play(1, "postreset_start_latency");
    wait_done(base_dones + 1, "postreset_done");
    check("postreset_queue_drained", exp_q.size(), 0);
    stop_play();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Parametrised, writable successor to the fixed song ROM. Holds 2^SONG_BITS songs of 2^IDX_W packed {note, duration} entries in a synchronous-read RAM loaded at run time, and plays the selected song. It steps through entries, counts duration in beat strobes, and presents the current note to the note player. It sits between the top-level control FSM (play/select/loop) and the note player.

## Interface

- NOTE_W, 6, note code width; 0 = rest
- DUR_W, 6, duration width in beats; 0 = end-of-song marker
- SONG_BITS, 2, log2 of song count
- IDX_W, 5, log2 of entries per song
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe for song memory
- wr_addr  in  SONG_BITS+IDX_W  write address {song, index}
- wr_data  in  NOTE_W+DUR_W  entry {note, duration}
- play  in  1  level; 1 = play, 0 = stop
- song_sel  in  SONG_BITS  song to play, latched at start
- loop  in  1  1 = restart song at end instead of finishing, sampled at each end event
- beat  in  1  one-cycle beat strobe
- note  out  NOTE_W  current note code, registered
- new_note  out  1  one-cycle pulse when note is loaded
- playing  out  1  high in FETCH, DECODE and PLAY
- song_done  out  1  one-cycle pulse at non-looping song end

## Operation

- Memory is 2^(SONG_BITS+IDX_W) x (NOTE_W+DUR_W).
  - Write: synchronous, accepted in every state.
  - Read: registered, 1-cycle latency. Address is {cur_song, idx}.
  - A read and write to the same address on the same edge returns the old data.
  - Reset does not clear memory.
- FSM states are IDLE, FETCH, DECODE, PLAY and DONE.
- IDLE:
  - Outputs note=0 and playing=0.
  - On play=1: cur_song<=song_sel, idx<=0, go to FETCH.
- FETCH: read register captures mem[{cur_song, idx}]; go to DECODE.
- DECODE:
  - If entry duration=0 (end event):
    - loop=1: idx<=0, go to FETCH.
    - loop=0: song_done pulse, go to DONE.
  - Otherwise: note<=entry note, new_note pulse, cnt<=duration, go to PLAY.
- PLAY, on beat:
  - If cnt=1 (advance):
    - idx=2^IDX_W-1: idx wrap, handled as an end event with the same loop/done rule, evaluated in this cycle.
    - Otherwise: idx<=idx+1, go to FETCH.
  - Otherwise: cnt<=cnt-1.
- DONE: note held at its last value; go to IDLE when play=0. No restart while play stays high.
- play=0 in FETCH, DECODE or PLAY: go to IDLE on the next edge with note<=0. Any pending new_note or song_done is suppressed. A later play=1 restarts from idx 0.
- play=0 has priority over beat and end events on the same edge.
- beat in FETCH or DECODE is ignored; it is not queued.
- song_sel changes during play are ignored until the next start from IDLE.
- Rest entries (note=0, duration≠0) play as normal notes with note=0 and a new_note pulse.

## Timing

- Reset values: state=IDLE, note=0, new_note=0, playing=0, song_done=0, idx=0, cnt=0.
- Start latency:
  - play sampled 1 at edge k → FETCH.
  - Edge k+1 → DECODE.
  - Edge k+2: note valid and new_note high in cycle k+2..k+3.
- A note with duration d remains in PLAY until the d-th beat edge.
- Inter-note gap is 2 cycles (FETCH, DECODE); note holds its old value during the gap.
- Loop restart gap is 4 cycles from the final beat (FETCH, DECODE of marker, FETCH, DECODE).
- new_note and song_done are never high together; each is exactly 1 cycle.
- Reset asserted mid-play: all outputs 0 immediately (asynchronous); memory intact.

## Test plan

- Reset check: hold reset with play=1 → note=0, playing=0, new_note=0, song_done=0 throughout; state IDLE after release.
- Basic song:
  - Stimulus: load song 1 = {5,2},{0,1},{9,3},{0,0}; song_sel=1, play=1, beat every 4 cycles.
  - Response: note sequence 5 (2 beats), 0 (1 beat), 9 (3 beats); 3 new_note pulses; first note 2 cycles after play; one song_done; playing=0; note stays 9 until play=0.
- Loop:
  - Stimulus: same song with loop=1, run 2 passes, then loop=0.
  - Response: 5 reappears 4 cycles after the final beat of 9, with no song_done while looping; after loop=0, song_done follows the next marker.
- Wrap:
  - Stimulus: song 2 with all 32 entries {k+1,1}, no marker.
  - Response: notes 1..32 each for 1 beat, then song_done on the 32nd beat's DECODE-equivalent cycle; no read from song 3.
- Stop/restart:
  - Stimulus: play=0 during the second beat of note 5, with a beat on the same edge.
  - Response: IDLE next cycle, note=0, no new_note.
  - Stimulus: play=1 again.
  - Response: restarts at entry 0, note=5.
- Edge cases:
  - Entry 0 duration=0 → song_done 2 cycles after play, no new_note.
  - Write the current fetch address on the FETCH edge → old data played.
  - Reset mid-note → outputs 0 asynchronously; replay gives identical notes.
